// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the pipelined vector CPU: debounces the start button, holds the
// pipeline in reset until a run, then runs, drains in-flight writes and parks in DONE.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DRAIN_CYCLES    = 4,
    parameter int WATCHDOG_CYCLES = 0,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_button,
    input  logic             image_select,
    input  logic             halt_seen,
    output logic             cpu_rst,
    output logic             fetch_freeze,
    output logic             img_sel,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DR_W-1:0]  DR_LAST = DR_W'(DRAIN_CYCLES - 1);
    localparam bit               WD_EN   = (WATCHDOG_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? WATCHDOG_CYCLES - 1 : 0);

    logic            btn_meta_q, btn_sync_q, img_meta_q, img_sync_q;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            start_pulse;

    state_t           state_q, state_d;
    logic [DR_W-1:0]  drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             img_q, img_d;
    logic             to_q, to_d;

    // The debounced level only moves after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_level_d  = db_level_q;
        db_cnt_d    = '0;
        start_pulse = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d  = btn_sync_q;
                start_pulse = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (start_pulse) state_d = LOAD;
            end
            LOAD: begin
                img_d   = img_sync_q;
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (halt_seen) begin
                    state_d = DRAIN;
                    drain_d = DR_LAST;
                end else if (WD_EN && (cnt_q == WD_LAST)) begin
                    state_d = DRAIN;
                    drain_d = DR_LAST;
                    to_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - 1'b1;
            end
            DONE: begin
                if (start_pulse) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            img_meta_q <= 1'b0;
            img_sync_q <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            drain_q    <= '0;
            cnt_q      <= '0;
            img_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            btn_meta_q <= start_button;
            btn_sync_q <= btn_meta_q;
            img_meta_q <= image_select;
            img_sync_q <= img_meta_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            drain_q    <= drain_d;
            cnt_q      <= cnt_d;
            img_q      <= img_d;
            to_q       <= to_d;
        end
    end

    // Pipeline controls decode from the state register so reset reaches them asynchronously.
    assign cpu_rst      = !((state_q == RUN) || (state_q == DRAIN));
    assign fetch_freeze = (state_q != RUN);
    assign busy         = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign img_sel      = img_q;
    assign timeout      = to_q;
    assign cycle_count  = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances with different drain/watchdog/width settings
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int NI  = 3;
    localparam int DEB = 4;
    localparam int DR_P [NI] = '{4, 2, 4};
    localparam int WD_P [NI] = '{0, 8, 0};
    localparam int CW_P [NI] = '{32, 32, 4};

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DRAIN = 3;
    localparam int S_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_button = 1'b0;
    logic image_select = 1'b0;
    logic halt_seen = 1'b0;

    logic        cpu_rst_w [NI];
    logic        ff_w      [NI];
    logic        img_w     [NI];
    logic        busy_w    [NI];
    logic        done_w    [NI];
    logic        to_w      [NI];
    logic [31:0] cc_w      [NI];
    logic [2:0]  st_w      [NI];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [CW_P[g]-1:0] cc_loc;
        cpu_run_ctrl #(
            .DEBOUNCE_CYCLES(DEB),
            .DRAIN_CYCLES   (DR_P[g]),
            .WATCHDOG_CYCLES(WD_P[g]),
            .CNT_W          (CW_P[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_button(start_button),
            .image_select(image_select),
            .halt_seen   (halt_seen),
            .cpu_rst     (cpu_rst_w[g]),
            .fetch_freeze(ff_w[g]),
            .img_sel     (img_w[g]),
            .busy        (busy_w[g]),
            .done        (done_w[g]),
            .timeout     (to_w[g]),
            .cycle_count (cc_loc),
            .state_dbg   (st_w[g])
        );
        assign cc_w[g] = 32'(cc_loc);
    end

    // ---------------- reference model ----------------
    bit          m_s1 [NI], m_s2 [NI], m_i1 [NI], m_i2 [NI];
    bit          m_level [NI];
    logic [31:0] m_hist [NI];
    int          m_hlen [NI];
    int          m_st [NI];
    bit          m_img [NI], m_to [NI];
    longint      m_cc [NI];
    int          m_drn [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
            m_level[k] = 0; m_hist[k] = '0; m_hlen[k] = 0;
            m_st[k] = S_IDLE; m_img[k] = 0; m_to[k] = 0; m_cc[k] = 0; m_drn[k] = 0;
        end
    endtask

    // One clock edge: the button level flips once the last DEB synced samples all disagree.
    task automatic model_step();
        logic [31:0] mask;
        bit          pulse;
        longint      mx, old;
        mask = (32'd1 << DEB) - 32'd1;
        for (int k = 0; k < NI; k++) begin
            m_hist[k] = {m_hist[k][30:0], m_s2[k]};
            if (m_hlen[k] < 32) m_hlen[k]++;
            pulse = 0;
            if (m_hlen[k] >= DEB && (m_hist[k] & mask) == (m_level[k] ? 32'h0 : mask)) begin
                m_level[k] = !m_level[k];
                pulse      = m_level[k];
                m_hist[k]  = '0;
                m_hlen[k]  = 0;
            end
            mx = (CW_P[k] >= 32) ? 64'hFFFF_FFFF : ((64'd1 << CW_P[k]) - 1);
            case (m_st[k])
                S_IDLE: if (pulse) m_st[k] = S_LOAD;
                S_LOAD: begin
                    m_img[k] = m_i2[k];
                    m_cc[k]  = 0;
                    m_to[k]  = 0;
                    m_st[k]  = S_RUN;
                end
                S_RUN: begin
                    old     = m_cc[k];
                    m_cc[k] = (old + 1 > mx) ? mx : old + 1;
                    if (halt_seen) begin
                        m_st[k] = S_DRAIN; m_drn[k] = 0;
                    end else if (WD_P[k] != 0 && old == longint'(WD_P[k] - 1)) begin
                        m_st[k] = S_DRAIN; m_drn[k] = 0; m_to[k] = 1;
                    end
                end
                S_DRAIN: begin
                    m_drn[k]++;
                    if (m_drn[k] == DR_P[k]) m_st[k] = S_DONE;
                end
                default: if (pulse) m_st[k] = S_LOAD;
            endcase
            m_s2[k] = m_s1[k]; m_s1[k] = start_button;
            m_i2[k] = m_i1[k]; m_i1[k] = image_select;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit in_run_drain;
        for (int k = 0; k < NI; k++) begin
            in_run_drain = (m_st[k] == S_RUN) || (m_st[k] == S_DRAIN);
            check($sformatf("state%0d", k),   32'(st_w[k]),      32'(m_st[k]));
            check($sformatf("cpu_rst%0d", k), 32'(cpu_rst_w[k]), 32'(!in_run_drain));
            check($sformatf("freeze%0d", k),  32'(ff_w[k]),      32'(m_st[k] != S_RUN));
            check($sformatf("busy%0d", k),    32'(busy_w[k]),
                  32'(m_st[k] == S_LOAD || in_run_drain));
            check($sformatf("done%0d", k),    32'(done_w[k]),    32'(m_st[k] == S_DONE));
            check($sformatf("img_sel%0d", k), 32'(img_w[k]),     32'(m_img[k]));
            check($sformatf("timeout%0d", k), 32'(to_w[k]),      32'(m_to[k]));
            check($sformatf("cycles%0d", k),  cc_w[k],           32'(m_cc[k]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
        check_all();
    endtask

    task automatic press(input int n);
        start_button = 1'b1;
        repeat (n) tick();
        start_button = 1'b0;
    endtask

    task automatic wait_run_cc(input int target);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_st[0] == S_RUN && m_cc[0] == longint'(target)) hit = 1;
            else tick();
        end
        check("wait_run", 32'(hit), 32'd1);
    endtask

    task automatic wait_done();
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_st[0] == S_DONE) hit = 1;
            else tick();
        end
        check("wait_done", 32'(hit), 32'd1);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // short glitch never reaches the debounce threshold
        press(3);
        repeat (8) tick();
        check("glitch_state", 32'(st_w[0]), S_IDLE);
        check("glitch_rst", 32'(cpu_rst_w[0]), 32'd1);

        // first run: LOAD six edges after the press, halt on the 20th RUN cycle
        image_select = 1'b1;
        repeat (3) tick();
        start_button = 1'b1;
        repeat (6) tick();
        check("load_latency", 32'(st_w[0]), S_LOAD);
        tick();
        check("img_one", 32'(img_w[0]), 32'd1);
        check("rst_release", 32'(cpu_rst_w[0]), 32'd0);
        check("busy_run", 32'(busy_w[0]), 32'd1);
        repeat (3) tick();
        start_button = 1'b0;
        wait_run_cc(19);
        halt_seen = 1'b1;
        tick();
        halt_seen = 1'b0;
        check("halt_cc", cc_w[0], 32'd20);
        check("wd_cc", cc_w[1], 32'd8);
        check("wd_timeout", 32'(to_w[1]), 32'd1);
        check("sat_cc", cc_w[2], 32'd15);
        for (int i = 0; i < 4; i++) begin
            check("drain_freeze", 32'(ff_w[0]), 32'd1);
            check("drain_rst", 32'(cpu_rst_w[0]), 32'd0);
            if (i < 3) tick();
        end
        tick();
        check("done_flag", 32'(done_w[0]), 32'd1);
        check("done_rst", 32'(cpu_rst_w[0]), 32'd1);
        check("halt_timeout", 32'(to_w[0]), 32'd0);

        // second run from DONE with image 0; halt on the same cycle as the watchdog limit
        image_select = 1'b0;
        start_button = 1'b1;
        repeat (6) tick();
        check("reload", 32'(st_w[0]), S_LOAD);
        tick();
        check("img_zero", 32'(img_w[0]), 32'd0);
        check("cc_clear", cc_w[1], 32'd0);
        check("to_clear", 32'(to_w[1]), 32'd0);
        repeat (3) tick();
        start_button = 1'b0;
        wait_run_cc(7);
        halt_seen = 1'b1;
        tick();
        halt_seen = 1'b0;
        check("tie_cc", cc_w[1], 32'd8);
        check("tie_timeout", 32'(to_w[1]), 32'd0);
        wait_done();

        // third run: a second press mid-run is ignored, then reset lands in DRAIN
        image_select = 1'b1;
        press(10);
        repeat (8) tick();
        press(8);
        check("repress_run", 32'(st_w[0]), S_RUN);
        halt_seen = 1'b1;
        tick();
        halt_seen = 1'b0;
        repeat (2) tick();
        check("pre_rst_drain", 32'(st_w[0]), S_DRAIN);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_state", 32'(st_w[0]), S_IDLE);
        check("arst_cpu_rst", 32'(cpu_rst_w[0]), 32'd1);
        check("arst_done", 32'(done_w[0]), 32'd0);
        check("arst_cc", cc_w[0], 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // random phase
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                start_button = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 19) == 0) image_select = ~image_select;
            halt_seen = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run sequencer for the pipelined vector CPU. It debounces the board start button and latches the image selection. It holds the pipeline in reset until a run is requested, releases it, and watches for a halt instruction or a watchdog timeout. It then drains the pipeline so in-flight MEM/WB writes retire, and parks the CPU in a done state for the GPU/VGA side to display results. It sits between the board buttons and the CPU top level, and drives the pipeline reset and fetch-freeze controls.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before the debounced level changes (min 1)
DRAIN_CYCLES, 4, cycles spent in DRAIN after halt, covering the EX/MEM/WB depth (min 1)
WATCHDOG_CYCLES, 0, RUN-cycle limit before forced stop; 0 disables the watchdog
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-low reset
start_button  in  1  raw button, active-high, asynchronous to clk
image_select  in  1  raw switch, sampled at run start
halt_seen  in  1  ID-stage decode of halt opcode, valid while CPU running
cpu_rst  out  1  active-high reset to pipeline registers and PC
fetch_freeze  out  1  holds PC/IF while asserted
img_sel  out  1  image_select latched at run start
busy  out  1  state is LOAD, RUN or DRAIN
done  out  1  state is DONE
timeout  out  1  last run ended by watchdog
cycle_count  out  CNT_W  RUN cycles of last/current run
state_dbg  out  3  encoded FSM state

Behaviour:
- Reset (rst=0, async): state=IDLE. cpu_rst=1, fetch_freeze=1, img_sel=0, busy=0, done=0, timeout=0, cycle_count=0. Synchronizers, debounce counter and drain counter cleared; debounced level=0.
- Input sync: start_button and image_select each pass through a 2-FF synchronizer before any use.
- Debounce: the counter increments while the synced start differs from the debounced level, and clears when they match. When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. start_pulse is a 1-cycle pulse on a debounced 0->1 transition. Release needs no action beyond updating the level.
- State encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
- IDLE: cpu_rst=1, fetch_freeze=1. start_pulse -> LOAD.
- LOAD (exactly 1 cycle): img_sel <= synced image_select, cycle_count <= 0, timeout <= 0. cpu_rst stays 1. Next state is RUN.
- RUN: cpu_rst=0, fetch_freeze=0. cycle_count increments every RUN cycle and saturates at all-ones (no wrap).
  - halt_seen=1 -> DRAIN.
  - Else, if WATCHDOG_CYCLES!=0 and cycle_count==WATCHDOG_CYCLES-1 -> DRAIN with timeout<=1.
  - If halt and the watchdog limit occur in the same cycle, halt wins and timeout stays 0.
  - The transition cycle still increments cycle_count.
- DRAIN: cpu_rst=0, fetch_freeze=1. The drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 -> DONE. DRAIN therefore lasts exactly DRAIN_CYCLES cycles. halt_seen is ignored here.
- DONE: cpu_rst=1, fetch_freeze=1, done=1. cycle_count, img_sel and timeout are held for display. start_pulse -> LOAD, starting a new run with a fresh image_select sample.
- start_pulse in LOAD, RUN or DRAIN is ignored and not queued.
- All outputs are registered or decoded from registered state only. No combinational path from raw inputs to outputs.
- Reset asserted mid-RUN or mid-DRAIN returns to IDLE immediately. cpu_rst goes 1 asynchronously and done stays 0.
- Data memory is never reset by this block; only the pipeline is held.

Test Plan:
1. Set DEBOUNCE_CYCLES=4, DRAIN_CYCLES=4. Release rst; press start for 10 cycles with image_select=1 -> LOAD is entered 2+4 cycles after the press edge, img_sel=1, cpu_rst falls one cycle later, busy=1.
2. 3-cycle glitch on start_button with DEBOUNCE_CYCLES=4 -> state stays IDLE and cpu_rst stays 1.
3. In RUN, assert halt_seen at the 20th RUN cycle -> cycle_count=20, fetch_freeze=1 for 4 DRAIN cycles with cpu_rst=0, then done=1, cpu_rst=1, timeout=0.
4. Set WATCHDOG_CYCLES=8 with no halt -> DRAIN after 8 RUN cycles, cycle_count=8, timeout=1. Also assert halt exactly at cycle 8 -> timeout=0.
5. From DONE, press start with image_select=0 -> LOAD, img_sel=0, cycle_count and timeout cleared. A second press during RUN has no effect.
6. Pull rst low during DRAIN -> asynchronous return to IDLE with cpu_rst=1, done=0, cycle_count=0. CNT_W=4 with a run of 20 cycles -> cycle_count saturates at 15.
